ps2_menu_keys: RTL and testbench

// - PS/2 keyboard receiver and scancode decoder that produces the menu key strobes
//   (arrow_up, arrow_down, enter, esc) consumed by the main menu / play state controller.
// - Sits between the board PS/2 pins and the menu FSM.
// - Each physical key press yields exactly one single-cycle strobe in the clk domain.

---
 rtl/ps2_menu_keys.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_menu_keys.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_menu_keys.sv
// PS/2 receiver + scancode decoder producing single-cycle menu key strobes.
// Latency: strobes/code_valid 1 clk after the cycle that detects the stop-bit falling edge.
// No backpressure: PS/2 is device-clocked, every completed byte is decoded immediately.
module ps2_menu_keys #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       arrow_up,
    output logic       arrow_down,
    output logic       enter,
    output logic       esc,
    output logic [7:0] key_code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    // Bit order for held/strobe vectors: [3]=up [2]=down [1]=enter [0]=esc
    logic [3:0]    held_q, held_d;
    logic [3:0]    strobe_q, strobe_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          code_valid_q, code_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [8:0]    menu_key;
    logic [3:0]    menu_hit;

    assign menu_key = {ext_q, shift_q};

    always_comb begin
        menu_hit = 4'b0000;
        case (menu_key)
            9'h175:         menu_hit = 4'b1000;
            9'h172:         menu_hit = 4'b0100;
            9'h05A, 9'h15A: menu_hit = 4'b0010;
            9'h076:         menu_hit = 4'b0001;
            default:        menu_hit = 4'b0000;
        endcase
    end

    always_comb begin
        clk_meta_d   = ps2_clk;
        clk_sync_d   = clk_meta_q;
        dat_meta_d   = ps2_data;
        dat_sync_d   = dat_meta_q;
        filt_d       = filt_q;
        filt_cnt_d   = filt_cnt_q;
        fall         = 1'b0;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        idle_cnt_d   = idle_cnt_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        held_d       = held_q;
        strobe_d     = 4'b0000;
        key_code_d   = key_code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        // Level flips only after FILTER_LEN consecutive samples disagreeing with it
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FLT_LAST) begin
                filt_d     = clk_sync_q;
                filt_cnt_d = '0;
                fall       = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end else begin
            filt_cnt_d = '0;
        end

        if (state_q == IDLE || fall) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_LAST) begin
            idle_cnt_d  = '0;
            state_d     = IDLE;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d = {dat_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end
                PARITY: begin
                    parity_d = dat_sync_q;
                    state_d  = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (dat_sync_q && (^{shift_q, parity_q})) begin
                        key_code_d   = shift_q;
                        code_valid_d = 1'b1;
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                            if (brk_q) begin
                                held_d = held_q & ~menu_hit;
                            end else if ((menu_hit & ~held_q) != 4'b0000) begin
                                // Typematic repeats find the held flag set and stay silent
                                held_d   = held_q | menu_hit;
                                strobe_d = menu_hit;
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            dat_meta_q   <= 1'b1;
            dat_sync_q   <= 1'b1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            idle_cnt_q   <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            held_q       <= 4'b0000;
            strobe_q     <= 4'b0000;
            key_code_q   <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_meta_q   <= clk_meta_d;
            clk_sync_q   <= clk_sync_d;
            dat_meta_q   <= dat_meta_d;
            dat_sync_q   <= dat_sync_d;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            idle_cnt_q   <= idle_cnt_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            held_q       <= held_d;
            strobe_q     <= strobe_d;
            key_code_q   <= key_code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign arrow_up   = strobe_q[3];
    assign arrow_down = strobe_q[2];
    assign enter      = strobe_q[1];
    assign esc        = strobe_q[0];
    assign key_code   = key_code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_menu_keys.sv
// Directed bench for ps2_menu_keys: frames are bit-banged on the PS/2 pins and
// every expected output event is queued, then matched when the DUT strobes.
module tb_ps2_menu_keys;

    localparam int FLT = 8;
    localparam int TO  = 1000;
    localparam int Q   = 10;
    localparam int H   = 20;

    typedef struct {
        logic       cv;
        logic [7:0] kc;
        logic       fe;
        logic [3:0] strb;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk, ps2_data;
    logic       arrow_up, arrow_down, enter, esc;
    logic [7:0] key_code;
    logic       code_valid, frame_err;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;
    ev_t  exp_q[$];
    logic [7:0] last_code = 8'h00;

    ps2_menu_keys #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .arrow_up(arrow_up), .arrow_down(arrow_down), .enter(enter), .esc(esc),
        .key_code(key_code), .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        ev_t        e;
        logic [13:0] obs;
        forever begin
            @(negedge clk);
            obs = {code_valid, key_code, frame_err, arrow_up, arrow_down, enter, esc};
            if (!reset && (code_valid || frame_err || arrow_up || arrow_down || enter || esc)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(obs), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("event_kc%02h", e.kc), 32'(obs), 32'({e.cv, e.kc, e.fe, e.strb}));
                    if (e.cyc >= 0) check($sformatf("latency_kc%02h", e.kc), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    // One PS/2 bit: data settles while clock is high, then clock low for H cycles
    task automatic ps2_bit(input logic d, input logic do_push, input ev_t e);
        ev_t t;
        ps2_data = d;
        repeat (Q) @(negedge clk);
        ps2_clk = 1'b0;
        if (do_push) begin
            t     = e;
            t.cyc = cyc + 2 + FLT;
            exp_q.push_back(t);
        end
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (Q) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic flip_par, input logic stop_bit,
                        input logic [3:0] strb);
        ev_t  e;
        logic p;
        logic fe;
        fe     = flip_par || !stop_bit;
        e.cv   = !fe;
        e.fe   = fe;
        e.kc   = fe ? last_code : b;
        e.strb = strb;
        e.cyc  = 0;
        if (!fe) last_code = b;
        p = flip_par ? (^b) : ~(^b);
        ps2_bit(1'b0, 1'b0, e);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, e);
        ps2_bit(p, 1'b0, e);
        ps2_bit(stop_bit, 1'b1, e);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    initial begin
        ev_t        none;
        ev_t        to_ev;
        logic [7:0] b;
        none = '{cv: 1'b0, kc: 8'h00, fe: 1'b0, strb: 4'b0000, cyc: 0};
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        fork
            monitor();
        join_none
        repeat (4) @(negedge clk);
        check("reset_strobes", 32'({arrow_up, arrow_down, enter, esc, code_valid, frame_err}), 32'h0);
        check("reset_key_code", 32'(key_code), 32'h00);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_key_code", 32'(key_code), 32'h00);

        // Esc make, then break: only the make strobes
        send(8'h76, 1'b0, 1'b1, 4'b0001);
        send(8'hF0, 1'b0, 1'b1, 4'b0000);
        send(8'h76, 1'b0, 1'b1, 4'b0000);

        // Arrow up with typematic repeats, break, and a fresh make
        for (int i = 0; i < 3; i++) begin
            send(8'hE0, 1'b0, 1'b1, 4'b0000);
            send(8'h75, 1'b0, 1'b1, (i == 0) ? 4'b1000 : 4'b0000);
        end
        send(8'hE0, 1'b0, 1'b1, 4'b0000);
        send(8'hF0, 1'b0, 1'b1, 4'b0000);
        send(8'h75, 1'b0, 1'b1, 4'b0000);
        send(8'hE0, 1'b0, 1'b1, 4'b0000);
        send(8'h75, 1'b0, 1'b1, 4'b1000);

        // Bad parity and bad stop bit: error only, key_code held
        send(8'h5A, 1'b1, 1'b1, 4'b0000);
        send(8'h76, 1'b0, 1'b0, 4'b0000);

        // Unknown extended code
        send(8'hE0, 1'b0, 1'b1, 4'b0000);
        send(8'h12, 1'b0, 1'b1, 4'b0000);

        // E0 prefix, then a truncated frame that times out and drops the prefix
        send(8'hE0, 1'b0, 1'b1, 4'b0000);
        b = 8'h72;
        to_ev = '{cv: 1'b0, kc: last_code, fe: 1'b1, strb: 4'b0000, cyc: -1};
        exp_q.push_back(to_ev);
        ps2_bit(1'b0, 1'b0, none);
        for (int i = 0; i < 4; i++) ps2_bit(b[i], 1'b0, none);
        ps2_data = 1'b1;
        repeat (TO + 100) @(negedge clk);
        check("timeout_drained", 32'(exp_q.size()), 32'd0);
        send(8'h72, 1'b0, 1'b1, 4'b0000);
        send(8'hE0, 1'b0, 1'b1, 4'b0000);
        send(8'h72, 1'b0, 1'b1, 4'b0100);

        // Short glitch on ps2_clk while idle must be ignored
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch_no_event", 32'(exp_q.size()), 32'd0);
        send(8'h5A, 1'b0, 1'b1, 4'b0010);

        // Reset during the parity bit of E0 clears held flags
        b = 8'hE0;
        ps2_bit(1'b0, 1'b0, none);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, none);
        ps2_data = ~(^b);
        repeat (Q) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_strobes", 32'({arrow_up, arrow_down, enter, esc, code_valid, frame_err}), 32'h0);
        check("midreset_key_code", 32'(key_code), 32'h00);
        reset     = 1'b0;
        last_code = 8'h00;
        ps2_data  = 1'b1;
        repeat (50) @(negedge clk);
        send(8'h5A, 1'b0, 1'b1, 4'b0010);

        repeat (100) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
